tick_to_level: RTL and testbench

//  Monostable pulse generator: converts a 1-cycle tick back into a level.
//  It is the inverse of the edge detectors (level -> tick). A qualifying tick

---
 rtl/tick_to_level_pkg.sv | 16 +
 rtl/tick_to_level_gap_timer.sv | 28 ++
 rtl/tick_to_level.sv | 122 ++++++++++++
 tb/tb_tick_to_level.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/tick_to_level_pkg.sv
// Shared types for the tick-to-level pulse stretcher: FSM states, latched
// pulse modes and the decoder that folds the reserved mode code into ONESHOT.
package tick_to_level_pkg;

    typedef enum logic [1:0] {IDLE, ACTIVE, GAP} pulse_state_t;
    typedef enum logic [1:0] {ONESHOT, RETRIG, TOGGLE} pulse_mode_t;

    function automatic pulse_mode_t decode_mode(input logic [1:0] mode_bits);
        case (mode_bits)
            2'b01:   return RETRIG;
            2'b10:   return TOGGLE;
            default: return ONESHOT;
        endcase
    endfunction

endpackage

// File: rtl/tick_to_level_gap_timer.sv
// Load/enable down-counter that times the forced low gap after each pulse.
// tc_o is high whenever the count has reached zero.
module gap_timer #(
    parameter int          GW   = 2,
    parameter int unsigned LOAD = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic en_i,
    output logic tc_o
);

    logic [GW-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= GW'(LOAD);
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - GW'(1);
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/tick_to_level.sv
// Monostable pulse generator: a qualifying 1-cycle tick drives `level` high
// for a programmable number of cycles (ONESHOT/RETRIG) or flips it (TOGGLE).
module tick_to_level
    import tick_to_level_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int MIN_GAP = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic [CNT_W-1:0] width,
    input  logic [1:0]       mode,
    input  logic             clr_ovr,
    output logic             level,
    output logic             busy,
    output logic             done,
    output logic             overrun,
    output logic [1:0]       dbg_state
);

    localparam int GAP_W = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;

    pulse_state_t     state_q;
    pulse_mode_t      mode_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q, busy_q, done_q, overrun_q;
    logic             ovr_set, reload, gap_load, gap_en, gap_tc;

    // A zero width is treated as one cycle, so the reload never underflows.
    assign cnt_d    = (width == '0) ? '0 : width - CNT_W'(1);
    assign reload   = tick && (mode_q == RETRIG);
    assign ovr_set  = tick && (((state_q == ACTIVE) && (mode_q != RETRIG)) || (state_q == GAP));
    assign gap_load = (state_q == ACTIVE) && (cnt_q == '0) && !reload;
    assign gap_en   = (state_q == GAP);

    generate
        if (MIN_GAP > 0) begin : g_gap
            gap_timer #(
                .GW   (GAP_W),
                .LOAD (MIN_GAP - 1)
            ) u_gap_timer (
                .clk    (clk),
                .reset  (reset),
                .load_i (gap_load),
                .en_i   (gap_en),
                .tc_o   (gap_tc)
            );
        end else begin : g_no_gap
            assign gap_tc = 1'b1;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            mode_q    <= ONESHOT;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (ovr_set) begin
                overrun_q <= 1'b1;
            end else if (clr_ovr) begin
                overrun_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (tick) begin
                        // A level left high by TOGGLE is cleared by the next timed-mode tick.
                        if (decode_mode(mode) == TOGGLE) begin
                            level_q <= ~level_q;
                        end else if (level_q) begin
                            level_q <= 1'b0;
                        end else begin
                            state_q <= ACTIVE;
                            mode_q  <= decode_mode(mode);
                            cnt_q   <= cnt_d;
                            level_q <= 1'b1;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ACTIVE: begin
                    if (reload) begin
                        cnt_q <= cnt_d;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        level_q <= 1'b0;
                        done_q  <= 1'b1;
                        if (MIN_GAP > 0) begin
                            state_q <= GAP;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                GAP: begin
                    if (gap_tc) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign level     = level_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign overrun   = overrun_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_tick_to_level.sv
// Bench for tick_to_level: a time-based reference model predicts the outputs
// after every edge; a monitor compares them against the DUT.
`timescale 1ns/100ps
module tb_tick_to_level;

    localparam int CNT_W   = 8;
    localparam int MIN_GAP = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             tick;
    logic [CNT_W-1:0] width;
    logic [1:0]       mode;
    logic             clr_ovr;
    logic             level, busy, done, overrun;
    logic [1:0]       dbg_state;

    logic [3:0] exp_q[$];
    logic [3:0] exp_v, got_v;
    int n_checks = 0;
    int n_fail   = 0;

    // Model: absolute edge index plus the edges at which the pulse falls and
    // the gap ends; levels are derived from those times.
    int k = 0;
    int end_e = 0;
    int gap_end = -1000;
    bit p_on = 0;
    bit m_retrig = 0;
    bit m_lvl = 0;
    bit m_ovr = 0;

    tick_to_level #(.CNT_W(CNT_W), .MIN_GAP(MIN_GAP)) dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .width     (width),
        .mode      (mode),
        .clr_ovr   (clr_ovr),
        .level     (level),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun),
        .dbg_state (dbg_state)
    );

    always #1 clk = ~clk;

    task automatic model_reset();
        p_on = 0; m_lvl = 0; m_ovr = 0; gap_end = -1000; end_e = 0;
    endtask

    task automatic model_edge(input bit t, input int w_in, input int m, input bit c,
                              output logic [3:0] e);
        int w;
        bit dn, set;
        w = (w_in == 0) ? 1 : w_in;
        dn = 0; set = 0;
        k++;
        if (p_on) begin
            if (t) begin
                if (m_retrig) end_e = k + w;
                else set = 1;
            end
            if (k == end_e) begin
                p_on = 0; m_lvl = 0; dn = 1; gap_end = k + MIN_GAP;
            end
        end else if (k <= gap_end) begin
            if (t) set = 1;
        end else if (t) begin
            if (m == 2) m_lvl = !m_lvl;
            else if (m_lvl) m_lvl = 0;
            else begin
                p_on = 1; m_lvl = 1; end_e = k + w; m_retrig = (m == 1);
            end
        end
        if (set) m_ovr = 1;
        else if (c) m_ovr = 0;
        e = {m_lvl, (p_on || (k < gap_end)), dn, m_ovr};
    endtask

    task automatic drive(input bit t, input int w, input int m, input bit c);
        logic [3:0] e;
        @(negedge clk);
        tick = t; width = CNT_W'(w); mode = 2'(m); clr_ovr = c;
        model_edge(t, w, m, c, e);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0);
    endtask

    task automatic check_reset_outputs(input string name);
        n_checks++;
        if ({level, busy, done, overrun} !== 4'b0000) begin
            n_fail++;
            $display("FAIL %s: lvl/busy/done/ovr=%b required 0000", name, {level, busy, done, overrun});
        end
    endtask

    always @(posedge clk) begin
        #0.5;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            got_v = {level, busy, done, overrun};
            n_checks++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL outputs at %0t: lvl/busy/done/ovr=%b required %b", $time, got_v, exp_v);
            end
        end
    end

    initial begin
        reset = 1'b0; tick = 1'b0; width = '0; mode = 2'b00; clr_ovr = 1'b0;
        #0.5;
        check_reset_outputs("reset_initial");
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();

        // ONESHOT width 4
        drive(1, 4, 0, 0); idle(8);
        // ONESHOT width 5, second tick dropped, then clear
        drive(1, 5, 0, 0); idle(1); drive(1, 5, 0, 0); idle(5); drive(0, 0, 0, 1); idle(4);
        // RETRIG width 3 with a retrigger, then retrigger at the last high edge
        drive(1, 3, 1, 0); idle(1); drive(1, 3, 1, 0); idle(7);
        drive(1, 3, 1, 0); idle(2); drive(1, 3, 1, 0); idle(6);
        // width 0 and width 255
        drive(1, 0, 0, 0); idle(4);
        drive(1, 255, 0, 0); idle(260);
        // tick in GAP together with clr_ovr
        drive(1, 2, 0, 0); idle(1); drive(1, 2, 0, 1); drive(0, 0, 0, 0); idle(4);
        drive(0, 0, 0, 1); idle(2);
        // TOGGLE, then leaving TOGGLE while level is high
        drive(1, 0, 2, 0); idle(2); drive(1, 0, 2, 0); idle(2);
        drive(1, 0, 2, 0); idle(1); drive(1, 6, 0, 0); idle(1); drive(1, 2, 0, 0); idle(6);

        for (int i = 0; i < 500; i++) begin
            drive($urandom_range(0, 99) < 30, $urandom_range(0, 6), $urandom_range(0, 3),
                  $urandom_range(0, 99) < 8);
        end
        idle(12);

        // Asynchronous reset mid-pulse
        drive(1, 10, 0, 0); idle(3);
        @(posedge clk);
        #0.7;
        reset = 1'b0;
        tick = 1'b0;
        #0.1;
        check_reset_outputs("reset_mid_pulse");
        model_reset();
        repeat (2) @(posedge clk);
        #0.5;
        check_reset_outputs("reset_held");
        @(negedge clk);
        reset = 1'b1;
        drive(1, 3, 1, 0); idle(6);

        repeat (3) @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drained: %0d entries left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
